// File: rtl/mfcc_pkg.sv
// Shared constants and FSM encoding for the MFCC front-end cepstral stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mfcc_pkg;

  localparam int NUM_FILT = 23;   // log filter-bank entries per frame
  localparam int NUM_CEP  = 13;   // cepstral coefficients per frame
  localparam int FRAC_COS = 14;   // fractional bits of the Q2.14 cosine table

  // Output saturation range (signed Q8.8 result)
  localparam int SAT_W   = 16;
  localparam int SAT_MAX = (2 ** (SAT_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (SAT_W - 1));

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/dct_cos_rom.sv
// Combinational DCT-II cosine ROM: coef = round(16384*cos(pi*k*(2n+1)/46)), Q2.14.
// Latency: zero cycles, purely combinational on {k, n}.
// Backpressure: none, stateless lookup.
module dct_cos_rom #(
  parameter int CW = 16
) (
  input  logic [3:0]           k,
  input  logic [4:0]           n,
  output logic signed [CW-1:0] coef
);

  // Quarter-wave table: round(16384*cos(pi*i/46)) for i = 0..23.
  // The full 13x23 table is folded onto this by cosine symmetry.
  function automatic logic [14:0] quarter(input logic [4:0] i);
    logic [14:0] v;
    case (i)
      5'd0:    v = 15'd16384;
      5'd1:    v = 15'd16346;
      5'd2:    v = 15'd16231;
      5'd3:    v = 15'd16041;
      5'd4:    v = 15'd15776;
      5'd5:    v = 15'd15438;
      5'd6:    v = 15'd15028;
      5'd7:    v = 15'd14547;
      5'd8:    v = 15'd13999;
      5'd9:    v = 15'd13385;
      5'd10:   v = 15'd12709;
      5'd11:   v = 15'd11974;
      5'd12:   v = 15'd11183;
      5'd13:   v = 15'd10340;
      5'd14:   v = 15'd9448;
      5'd15:   v = 15'd8513;
      5'd16:   v = 15'd7538;
      5'd17:   v = 15'd6527;
      5'd18:   v = 15'd5487;
      5'd19:   v = 15'd4420;
      5'd20:   v = 15'd3333;
      5'd21:   v = 15'd2231;
      5'd22:   v = 15'd1118;
      default: v = 15'd0;
    endcase
    return v;
  endfunction

  logic [9:0]    m;     // phase index k*(2n+1), in units of pi/46
  logic [6:0]    r;     // phase reduced to one period (92 units)
  logic [4:0]    qi;    // quarter-wave table index
  logic          neg;   // result lies in the negative half
  logic [CW-1:0] mag;

  // Reduce the phase to one period and fold it onto the first quadrant
  always_comb begin
    m   = {6'd0, k} * {4'd0, n, 1'b1};
    r   = 7'(m % 10'd92);
    qi  = 5'd0;
    neg = 1'b0;
    if (r <= 7'd23) begin
      qi  = r[4:0];
    end else if (r <= 7'd46) begin
      qi  = 5'(7'd46 - r);
      neg = 1'b1;
    end else if (r <= 7'd69) begin
      qi  = 5'(r - 7'd46);
      neg = 1'b1;
    end else begin
      qi  = 5'(7'd92 - r);
    end
    mag  = CW'(quarter(qi));
    coef = neg ? -mag : mag;
  end

endmodule

// File: rtl/dct_cepstrum.sv
// Cepstral DCT engine: sweeps the log-energy register file and streams c_0..c_12.
// Latency: 25 cycles per coefficient (23 MAC, 1 drain, 1 output) with ready high.
// Backpressure: cep_ready low holds the output register; accumulator and rf_addr freeze.
module dct_cepstrum #(
  parameter int NUM_FILT = mfcc_pkg::NUM_FILT,
  parameter int NUM_CEP  = mfcc_pkg::NUM_CEP,
  parameter int DW       = 16,
  parameter int CW       = 16,
  parameter int ACCW     = 37
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [4:0]    rf_addr,
  input  logic [DW-1:0] rf_rdata,
  output logic [DW-1:0] cep_data,
  output logic [3:0]    cep_idx,
  output logic          cep_valid,
  input  logic          cep_ready
);

  import mfcc_pkg::*;

  localparam int PW = DW + CW;
  localparam logic [4:0] N_LAST = 5'(NUM_FILT - 1);
  localparam logic [3:0] K_LAST = 4'(NUM_CEP - 1);
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(SAT_MAX);
  localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(SAT_MIN);
  localparam logic signed [ACCW-1:0] RND    = ACCW'(1) <<< (FRAC_COS - 1);

  state_t state, state_nxt;

  logic [3:0]             k;
  logic [4:0]             n;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_final;
  logic signed [ACCW-1:0] rounded;
  logic [DW-1:0]          sat_val;
  logic signed [DW-1:0]   rd_s;
  logic signed [CW-1:0]   coef;

  assign rd_s    = $signed(rf_rdata);
  // n only moves during ACC, so the address naturally holds outside it
  assign rf_addr = n;

  dct_cos_rom #(
    .CW (CW)
  ) u_cos_rom (
    .k    (k),
    .n    (n),
    .coef (coef)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACC;
      end
      ACC: begin
        busy = 1'b1;
        if (n == N_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        busy = 1'b1;
        if (cep_ready) state_nxt = (k == K_LAST) ? FIN : ACC;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fold in the last product, round half-up to Q8.8 and clamp to 16 bits
  always_comb begin
    acc_final = acc + ACCW'(prod);
    rounded   = (acc_final + RND) >>> FRAC_COS;
    if (rounded > SAT_HI)      sat_val = DW'(SAT_MAX);
    else if (rounded < SAT_LO) sat_val = DW'(SAT_MIN);
    else                       sat_val = rounded[DW-1:0];
  end

  // Counters, MAC pipeline (product register then accumulator) and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      n         <= '0;
      prod      <= '0;
      acc       <= '0;
      cep_data  <= '0;
      cep_idx   <= '0;
      cep_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k    <= '0;
            n    <= '0;
            prod <= '0;
            acc  <= '0;
          end
        end
        ACC: begin
          prod <= PW'(rd_s) * PW'(coef);
          acc  <= acc + ACCW'(prod);
          if (n != N_LAST) n <= n + 5'd1;
        end
        DRAIN: begin
          cep_data  <= sat_val;
          cep_idx   <= k;
          cep_valid <= 1'b1;
        end
        OUT: begin
          if (cep_ready) begin
            cep_valid <= 1'b0;
            if (k != K_LAST) begin
              k    <= k + 4'd1;
              n    <= '0;
              prod <= '0;
              acc  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_cepstrum.sv
// Self-checking bench for dct_cepstrum: directed sweeps with random register-file
// contents, checked cycle by cycle against a floating-point DCT reference and a
// timeline derived from the 25-cycles-per-coefficient handshake rules.
module tb_dct_cepstrum;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rf_addr;
  logic [15:0] rf_rdata;
  logic [15:0] cep_data;
  logic [3:0]  cep_idx;
  logic        cep_valid;
  logic        cep_ready;

  logic signed [15:0] rf [0:22];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign rf_rdata = (rf_addr < 5'd23) ? rf[rf_addr] : 16'd0;

  dct_cepstrum dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .cep_data  (cep_data),
    .cep_idx   (cep_idx),
    .cep_valid (cep_valid),
    .cep_ready (cep_ready)
  );

  function automatic int cosq(int k, int n);
    real a;
    a = PI * k * (2 * n + 1) / 46.0;
    return int'(16384.0 * $cos(a));
  endfunction

  function automatic logic [15:0] model_c(int k);
    longint acc;
    longint r;
    acc = 0;
    for (int n = 0; n < 23; n++) acc += longint'(rf[n]) * longint'(cosq(k, n));
    r = (acc + 8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] exp,
                     input string tag, input int c);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  // Run one sweep. stall: cycles cep_ready is held low when c_0 first appears.
  // restart_at: cycle with a spurious start pulse. abort_at: cycle reset is driven.
  task automatic sweep(input int stall, input int restart_at, input int abort_at);
    logic [15:0] exp_c [0:12];
    int  k_exp, v, h, done_c;
    bit  finished;
    bit  exp_v;
    for (int k = 0; k < 13; k++) exp_c[k] = model_c(k);
    k_exp = 0; v = 25; h = 25 + stall; done_c = -10; finished = 0;
    @(negedge clk); start = 1'b1; cep_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 1000 && !finished; c++) begin
      exp_v = (k_exp <= 12) && (c >= v) && (c <= h);
      chk(cep_valid, exp_v, "valid", c);
      chk(busy, k_exp <= 12, "busy", c);
      chk(done, c == done_c, "done", c);
      if (exp_v) begin
        chk(cep_idx, k_exp, "idx", c);
        chk(cep_data, exp_c[k_exp], "data", c);
        chk(rf_addr, 22, "addr_hold", c);
      end
      if (k_exp <= 12 && c >= v - 24 && c <= v - 2)
        chk(rf_addr, c - (v - 24), "addr_seq", c);
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk(busy, 0, "abort_busy", c + 1);
        chk(done, 0, "abort_done", c + 1);
        chk(cep_valid, 0, "abort_valid", c + 1);
        chk(cep_data, 0, "abort_data", c + 1);
        chk(cep_idx, 0, "abort_idx", c + 1);
        chk(rf_addr, 0, "abort_addr", c + 1);
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          chk(cep_valid, 0, "post_abort_valid", c + 2 + i);
          chk(done, 0, "post_abort_done", c + 2 + i);
          chk(busy, 0, "post_abort_busy", c + 2 + i);
        end
        cep_ready = 1'b1;
        return;
      end
      cep_ready = !(c >= 25 && c < 25 + stall);
      start     = (c == restart_at);
      if (k_exp <= 12 && c == h) begin
        k_exp++;
        if (k_exp == 13) done_c = c + 1;
        else begin
          v = h + 25;
          h = v;
        end
      end
      if (c == done_c + 1) finished = 1;
      @(negedge clk);
    end
    start     = 1'b0;
    cep_ready = 1'b1;
    chk(finished, 1, "sweep_end", 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cep_ready = 1'b1;
    for (int n = 0; n < 23; n++) rf[n] = 16'sd0;
    repeat (3) @(negedge clk);
    chk(busy, 0, "rst_busy", 0);
    chk(done, 0, "rst_done", 0);
    chk(cep_valid, 0, "rst_valid", 0);
    chk(cep_data, 0, "rst_data", 0);
    chk(cep_idx, 0, "rst_idx", 0);
    chk(rf_addr, 0, "rst_addr", 0);
    reset = 1'b0;
    @(negedge clk);
    chk(busy, 0, "idle_busy", 0);

    // Flat spectrum: only c_0 non-zero
    for (int n = 0; n < 23; n++) rf[n] = 16'sd256;
    sweep(0, -1, -1);

    // Impulse at n = 0
    for (int n = 0; n < 23; n++) rf[n] = 16'sd0;
    rf[0] = 16'sd256;
    sweep(0, -1, -1);

    // Positive and negative saturation
    for (int n = 0; n < 23; n++) rf[n] = 16'sd32767;
    sweep(0, -1, -1);
    for (int n = 0; n < 23; n++) rf[n] = -16'sd32768;
    sweep(0, -1, -1);

    // Random data, 10-cycle backpressure on c_0
    for (int n = 0; n < 23; n++) rf[n] = 16'($urandom);
    sweep(10, -1, -1);

    // Random data, spurious start while busy
    for (int n = 0; n < 23; n++) rf[n] = 16'($urandom_range(0, 4095)) - 16'sd2048;
    sweep(0, 100, -1);

    // Reset mid-sweep, then a fresh full sweep
    for (int n = 0; n < 23; n++) rf[n] = 16'($urandom);
    sweep(0, -1, 60);
    for (int n = 0; n < 23; n++) rf[n] = 16'($urandom_range(0, 8191)) - 16'sd4096;
    sweep(0, -1, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
